control_unit: RTL and testbench
===============================

# control_unit

Moore-style sequencer that generates every datapath and memory strobe of the `System` CPU, one control step per `Clock`, from the instruction in IR. It sits directly upstream of the `System` datapath and replaces hand-written per-instruction stimulus: its outputs connect one-to-one to the `System` control inputs, and it consumes `IR` and `con_ff_bit` back from the datapath.

## Interface

- `DATA_WIDTH`, 32, IR width.
- `Clock` in 1: single clock. All state updates occur on the rising edge.
- `clear` in 1: reset. It is synchronous and active-high.
- `Stop` in 1: halt request, sampled at instruction end.
- `IR` in 32: instruction register contents. Bits [31:27] are the opcode; bits [22:19] are C2 of `brzr`/`brnz`/`brpl`/`brmi`.
- `con_ff_bit` in 1: branch condition result.
- `Run` out 1: 1 while executing. 0 in `S_RESET` and `S_HALT`.
- Strobes, out 1 each:
  - Bus sources: `HIout`, `LOout`, `Zhi_out`, `Zlo_out`, `PCout`, `MDRout`, `Inport_out`, `Cout`.
  - Register loads: `MARin`, `Zin`, `PCin`, `MDRin`, `IRin`, `Yin`, `HIin`, `LOin`, `CONin`, `outport_in`.
  - Control: `IncPC`, `Gra`, `Grb`, `Grc`, `Rin`, `Rout`, `BAout`, `Mem_Read`, `Mem_Write`, `Mem_enable512x32`.
- `opcode` out 5: ALU operation code.

## Operation

**Output model**
- Outputs are a pure decode of the registered state and IR[31:27].
- Any strobe not listed for a step is 0.
- `opcode` = 5'b00000 except in steps marked ALU.
  - In ALU steps it equals IR[31:27], or 5'b00011 (add) where marked "add".

**Fetch (all instructions)**
- T0: `PCout` `IncPC` `MARin` `Zin`.
- T1: `Zlo_out` `PCin` `MDRin` `Mem_Read` `Mem_enable512x32`.
- T2: `MDRout` `IRin`.
- At the T2→T3 edge, the class is decoded from the newly loaded IR[31:27].

**Execute steps by opcode**
- ld 00000:
  - T3 `Grb` `BAout` `Yin`; T4 `Cout` `Zin` add.
  - T5 `Zlo_out` `MARin`; T6 `Mem_Read` `Mem_enable512x32` `MDRin`; T7 `MDRout` `Gra` `Rin`.
- ldi 00001: T3 `Grb` `BAout` `Yin`; T4 `Cout` `Zin` add; T5 `Zlo_out` `Gra` `Rin`.
- st 00010:
  - T3–T5 identical to ld.
  - T6 `Gra` `Rout` `MDRin`; T7 `Mem_Write` `Mem_enable512x32`.
- Register ALU 00011–01011 (add, sub, shr, shra, shl, ror, rol, and, or): T3 `Grb` `Rout` `Yin`; T4 `Grc` `Rout` `Zin` ALU; T5 `Zlo_out` `Gra` `Rin`.
- Immediate ALU 01100–01110 (addi, andi, ori): T3 `Grb` `Rout` `Yin`; T4 `Cout` `Zin` ALU; T5 `Zlo_out` `Gra` `Rin`.
- mul/div 01111, 10000: T3 `Gra` `Rout` `Yin`; T4 `Grb` `Rout` `Zin` ALU; T5 `Zlo_out` `LOin`; T6 `Zhi_out` `HIin`.
- neg/not 10001, 10010: T3 `Grb` `Rout` `Zin` ALU; T4 `Zlo_out` `Gra` `Rin`.
- branch 10011:
  - T3 `Gra` `Rout` `CONin`; T4 `PCout` `Yin`; T5 `Cout` `Zin` add.
  - T6 `Zlo_out`, plus `PCin` only if `con_ff_bit`=1.
- jr 10100: T3 `Gra` `Rout` `PCin`.
- jal 10101: T3 `PCout` `Grb` `Rin` (link written to the Rb field, r15 by encoding); T4 `Gra` `Rout` `PCin`.
- in 10110: T3 `Inport_out` `Gra` `Rin`.
- out 10111: T3 `Gra` `Rout` `outport_in`.
- mfhi 11000: T3 `HIout` `Gra` `Rin`.
- mflo 11001: T3 `LOout` `Gra` `Rin`.
- nop 11010, and all undefined opcodes 11100–11111: no execute steps; T2 goes directly to T0.
- halt 11011: T2 → `S_HALT`.

**State transitions**
- `S_RESET` → T0 on the first edge with `clear`=0.
- Last step of any instruction → T0, or → `S_HALT` if `Stop`=1 on that edge.
- `S_HALT` is sticky: it is left only via `clear`.
- `clear`=1 on any edge forces `S_RESET`, including mid-instruction and from `S_HALT`; it overrides `Stop`.

## Timing

- Reset values: state `S_RESET`; every strobe 0, `opcode` 0, `Run` 0. These hold from the edge where `clear` is sampled high.
- One step per `Clock` cycle; no wait states. Memory is assumed to return data within the step that asserts `Mem_Read`.
- Instruction length in cycles, fetch included:
  - ld/st 8.
  - mul/div, branch 7.
  - ldi, ALU, imm-ALU 6.
  - neg/not, jal 5.
  - jr, in, out, mfhi, mflo 4.
  - nop 3.
- `Run` rises on the cycle T0 is first entered and falls on entry to `S_HALT`/`S_RESET`.
- `con_ff_bit` is sampled combinationally during branch T6 only. CON was loaded at the T3→T4 edge.
- IR is assumed stable from the T2→T3 edge until the next T2.

## Test plan

- **Reset.** Hold `clear`=1 for 3 cycles mid-ld (state T5), then release → all outputs 0 while clear is high; T0 strobes (`PCout` `IncPC` `MARin` `Zin`) appear exactly 1 cycle after release.
- **ldi.** IR=0x0B000003 (ldi r6,3) → 6-cycle sequence. T4 `opcode`=00011 with `Cout` `Zin`; T5 `Zlo_out` `Gra` `Rin`; the next cycle is T0.
- **jr then jal.** IR=0xA3000000 (jr r6), then 0xAB780000 (jal r6,r15) → jr T3 `Gra` `Rout` `PCin`, 4 cycles total. jal T3 `PCout` `Grb` `Rin`, T4 `Gra` `Rout` `PCin`, 5 cycles total.
- **Branch.** Branch with `con_ff_bit`=0 vs 1 → T6 `Zlo_out` in both cases; `PCin` only when `con_ff_bit`=1. 7 cycles each.
- **Stop and halt.** Assert `Stop` during the final step of an add → `S_HALT`, `Run`=0 next cycle, all strobes 0 thereafter. IR=halt (11011) → `S_HALT` after T2. A later `clear` pulse restarts at T0.
- **Memory ops.** Check ld and st (8 cycles each), mul (`LOin` at T5, `HIin` at T6), and undefined opcode 11111 (3 cycles, no execute strobes).

Source files
------------

// File: rtl/control_unit.sv
// control_unit: Moore sequencer producing every datapath/memory strobe of the System CPU, one step per Clock.
module control_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  Clock,
  input  logic                  clear,
  input  logic                  Stop,
  input  logic [DATA_WIDTH-1:0] IR,
  input  logic                  con_ff_bit,
  output logic                  Run,
  output logic                  HIout,
  output logic                  LOout,
  output logic                  Zhi_out,
  output logic                  Zlo_out,
  output logic                  PCout,
  output logic                  MDRout,
  output logic                  Inport_out,
  output logic                  Cout,
  output logic                  MARin,
  output logic                  Zin,
  output logic                  PCin,
  output logic                  MDRin,
  output logic                  IRin,
  output logic                  Yin,
  output logic                  HIin,
  output logic                  LOin,
  output logic                  CONin,
  output logic                  outport_in,
  output logic                  IncPC,
  output logic                  Gra,
  output logic                  Grb,
  output logic                  Grc,
  output logic                  Rin,
  output logic                  Rout,
  output logic                  BAout,
  output logic                  Mem_Read,
  output logic                  Mem_Write,
  output logic                  Mem_enable512x32,
  output logic [4:0]            opcode
);
  typedef enum logic [3:0] {S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_RESET, S_HALT} state_t;
  state_t state, next;
  logic [4:0] op;
  logic [2:0] last;
  logic is_ld, is_ldi, is_st, is_alu, is_imm, is_md, is_nn, is_br, is_jr, is_jal;
  logic is_in, is_out, is_mfhi, is_mflo, is_halt;
  logic unused;
  assign op      = IR[DATA_WIDTH-1:DATA_WIDTH-5];
  assign unused  = ^IR[DATA_WIDTH-6:0];
  assign is_ld   = op == 5'd0;
  assign is_ldi  = op == 5'd1;
  assign is_st   = op == 5'd2;
  assign is_alu  = op >= 5'd3 && op <= 5'd11;
  assign is_imm  = op >= 5'd12 && op <= 5'd14;
  assign is_md   = op == 5'd15 || op == 5'd16;
  assign is_nn   = op == 5'd17 || op == 5'd18;
  assign is_br   = op == 5'd19;
  assign is_jr   = op == 5'd20;
  assign is_jal  = op == 5'd21;
  assign is_in   = op == 5'd22;
  assign is_out  = op == 5'd23;
  assign is_mfhi = op == 5'd24;
  assign is_mflo = op == 5'd25;
  assign is_halt = op == 5'd27;
  // Index of the final T-step for the current instruction class; nop/halt/undefined end at T2.
  assign last = (is_ld || is_st) ? 3'd7 :
                (is_md || is_br) ? 3'd6 :
                (is_ldi || is_alu || is_imm) ? 3'd5 :
                (is_nn || is_jal) ? 3'd4 :
                (is_jr || is_in || is_out || is_mfhi || is_mflo) ? 3'd3 : 3'd2;
  always_ff @(posedge Clock)
    if (clear) state <= S_RESET;
    else state <= next;
  always_comb begin
    next = state_t'(state + 4'd1);
    if (state == S_RESET) next = S_T0;
    else if (state == S_HALT) next = S_HALT;
    else if (state[2:0] == last) next = (Stop || (state == S_T2 && is_halt)) ? S_HALT : S_T0;
  end
  always_comb begin
    {HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout} = '0;
    {MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, CONin, outport_in} = '0;
    {IncPC, Gra, Grb, Grc, Rin, Rout, BAout, Mem_Read, Mem_Write, Mem_enable512x32} = '0;
    opcode = '0;
    Run = state != S_RESET && state != S_HALT;
    case (state)
      S_T0: {PCout, IncPC, MARin, Zin} = '1;
      S_T1: {Zlo_out, PCin, MDRin, Mem_Read, Mem_enable512x32} = '1;
      S_T2: {MDRout, IRin} = '1;
      S_T3:
        if (is_ld || is_ldi || is_st) {Grb, BAout, Yin} = '1;
        else if (is_alu || is_imm) {Grb, Rout, Yin} = '1;
        else if (is_md) {Gra, Rout, Yin} = '1;
        else if (is_nn) begin
          {Grb, Rout, Zin} = '1;
          opcode = op;
        end
        else if (is_br) {Gra, Rout, CONin} = '1;
        else if (is_jr) {Gra, Rout, PCin} = '1;
        else if (is_jal) {PCout, Grb, Rin} = '1;
        else if (is_in) {Inport_out, Gra, Rin} = '1;
        else if (is_out) {Gra, Rout, outport_in} = '1;
        else if (is_mfhi) {HIout, Gra, Rin} = '1;
        else if (is_mflo) {LOout, Gra, Rin} = '1;
      S_T4:
        if (is_ld || is_ldi || is_st) begin
          {Cout, Zin} = '1;
          opcode = 5'd3;
        end
        else if (is_alu || is_imm || is_md) begin
          {Zin, Rout} = {1'b1, !is_imm};
          {Grc, Cout, Grb} = {is_alu, is_imm, is_md};
          opcode = op;
        end
        else if (is_nn) {Zlo_out, Gra, Rin} = '1;
        else if (is_br) {PCout, Yin} = '1;
        else if (is_jal) {Gra, Rout, PCin} = '1;
      S_T5:
        if (is_ld || is_st) {Zlo_out, MARin} = '1;
        else if (is_ldi || is_alu || is_imm) {Zlo_out, Gra, Rin} = '1;
        else if (is_md) {Zlo_out, LOin} = '1;
        else if (is_br) begin
          {Cout, Zin} = '1;
          opcode = 5'd3;
        end
      S_T6:
        if (is_ld) {Mem_Read, Mem_enable512x32, MDRin} = '1;
        else if (is_st) {Gra, Rout, MDRin} = '1;
        else if (is_md) {Zhi_out, HIin} = '1;
        else if (is_br) {Zlo_out, PCin} = {1'b1, con_ff_bit};
      S_T7:
        if (is_ld) {MDRout, Gra, Rin} = '1;
        else if (is_st) {Mem_Write, Mem_enable512x32} = '1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: randomized scoreboard bench; expected per-cycle strobe sets come from a per-instruction step table.
module tb_control_unit;
  logic Clock = 0, clear = 1, Stop = 0, con_ff_bit = 0;
  logic [31:0] IR = '0;
  logic Run, HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout;
  logic MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, CONin, outport_in;
  logic IncPC, Gra, Grb, Grc, Rin, Rout, BAout, Mem_Read, Mem_Write, Mem_enable512x32;
  logic [4:0] opcode;
  int checks = 0, errors = 0;
  logic [33:0] exp_q[$];
  logic [33:0] obs;

  control_unit #(.DATA_WIDTH(32)) dut (
    .Clock(Clock), .clear(clear), .Stop(Stop), .IR(IR), .con_ff_bit(con_ff_bit), .Run(Run),
    .HIout(HIout), .LOout(LOout), .Zhi_out(Zhi_out), .Zlo_out(Zlo_out), .PCout(PCout),
    .MDRout(MDRout), .Inport_out(Inport_out), .Cout(Cout), .MARin(MARin), .Zin(Zin),
    .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .HIin(HIin), .LOin(LOin),
    .CONin(CONin), .outport_in(outport_in), .IncPC(IncPC), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .Rin(Rin), .Rout(Rout), .BAout(BAout), .Mem_Read(Mem_Read), .Mem_Write(Mem_Write),
    .Mem_enable512x32(Mem_enable512x32), .opcode(opcode)
  );

  always #5 Clock = ~Clock;

  assign obs = {Run, HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout,
                MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, CONin, outport_in,
                IncPC, Gra, Grb, Grc, Rin, Rout, BAout, Mem_Read, Mem_Write, Mem_enable512x32, opcode};

  localparam logic [33:0] ADD  = 34'd3;
  localparam logic [33:0] ME   = 34'd1 << 5,  MW   = 34'd1 << 6,  MR   = 34'd1 << 7;
  localparam logic [33:0] BAO  = 34'd1 << 8,  ROUT = 34'd1 << 9,  RIN  = 34'd1 << 10;
  localparam logic [33:0] GRC  = 34'd1 << 11, GRB  = 34'd1 << 12, GRA  = 34'd1 << 13;
  localparam logic [33:0] INC  = 34'd1 << 14, OUTI = 34'd1 << 15, CONI = 34'd1 << 16;
  localparam logic [33:0] LOI  = 34'd1 << 17, HII  = 34'd1 << 18, YIN  = 34'd1 << 19;
  localparam logic [33:0] IRI  = 34'd1 << 20, MDRI = 34'd1 << 21, PCI  = 34'd1 << 22;
  localparam logic [33:0] ZIN  = 34'd1 << 23, MAR  = 34'd1 << 24, COUT = 34'd1 << 25;
  localparam logic [33:0] INO  = 34'd1 << 26, MDRO = 34'd1 << 27, PCO  = 34'd1 << 28;
  localparam logic [33:0] ZLO  = 34'd1 << 29, ZHO  = 34'd1 << 30, LOO  = 34'd1 << 31;
  localparam logic [33:0] HIO  = 34'd1 << 32, RUN  = 34'd1 << 33;

  function automatic int ilen(input logic [4:0] op);
    if (op == 0 || op == 2) return 8;
    if (op == 15 || op == 16 || op == 19) return 7;
    if (op == 1 || (op >= 3 && op <= 14)) return 6;
    if (op == 17 || op == 18 || op == 21) return 5;
    if (op >= 20 && op <= 25) return 4;
    return 3;
  endfunction

  function automatic logic [33:0] exp_step(input logic [4:0] op, input logic con, input int t);
    logic [33:0] e, opv;
    opv = {29'd0, op};
    e = RUN;
    if (t == 0) e |= PCO | INC | MAR | ZIN;
    else if (t == 1) e |= ZLO | PCI | MDRI | MR | ME;
    else if (t == 2) e |= MDRO | IRI;
    else if (op <= 2)
      case (t)
        3: e |= GRB | BAO | YIN;
        4: e |= COUT | ZIN | ADD;
        5: e |= (op == 1) ? (ZLO | GRA | RIN) : (ZLO | MAR);
        6: e |= (op == 0) ? (MR | ME | MDRI) : (GRA | ROUT | MDRI);
        7: e |= (op == 0) ? (MDRO | GRA | RIN) : (MW | ME);
        default: ;
      endcase
    else if (op <= 14)
      case (t)
        3: e |= GRB | ROUT | YIN;
        4: e |= ((op <= 11) ? (GRC | ROUT) : COUT) | ZIN | opv;
        5: e |= ZLO | GRA | RIN;
        default: ;
      endcase
    else if (op <= 16)
      case (t)
        3: e |= GRA | ROUT | YIN;
        4: e |= GRB | ROUT | ZIN | opv;
        5: e |= ZLO | LOI;
        6: e |= ZHO | HII;
        default: ;
      endcase
    else if (op <= 18) e |= (t == 3) ? (GRB | ROUT | ZIN | opv) : (ZLO | GRA | RIN);
    else if (op == 19)
      case (t)
        3: e |= GRA | ROUT | CONI;
        4: e |= PCO | YIN;
        5: e |= COUT | ZIN | ADD;
        6: e |= ZLO | (con ? PCI : 34'd0);
        default: ;
      endcase
    else if (op == 20) e |= GRA | ROUT | PCI;
    else if (op == 21) e |= (t == 3) ? (PCO | GRB | RIN) : (GRA | ROUT | PCI);
    else if (op == 22) e |= INO | GRA | RIN;
    else if (op == 23) e |= GRA | ROUT | OUTI;
    else if (op == 24) e |= HIO | GRA | RIN;
    else if (op == 25) e |= LOO | GRA | RIN;
    return e;
  endfunction

  task automatic cyc(input logic [33:0] e, input logic clr, input logic stp);
    exp_q.push_back(e);
    clear = clr;
    Stop = stp;
    @(posedge Clock);
    #1;
  endtask

  task automatic run(input logic [31:0] ir, input logic con, input logic stp_end);
    int n;
    IR = ir;
    con_ff_bit = con;
    n = ilen(ir[31:27]);
    for (int t = 0; t < n; t++) cyc(exp_step(ir[31:27], con, t), 1'b0, stp_end && t == n - 1);
  endtask

  task automatic halted_restart(input int k);
    for (int i = 0; i < k; i++) cyc(34'd0, 1'b0, 1'($urandom_range(0, 1)));
    cyc(34'd0, 1'b1, 1'b1);
    cyc(34'd0, 1'b0, 1'b0);
  endtask

  always @(negedge Clock)
    if (exp_q.size() > 0) begin
      logic [33:0] e;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL outputs @%0t: got %h expected %h (IR=%h)", $time, obs, e, IR);
      end
    end

  initial begin
    logic [4:0] op;
    logic [31:0] ir;
    logic stp;
    @(posedge Clock);
    #1;
    cyc(34'd0, 1'b1, 1'b0);
    cyc(34'd0, 1'b0, 1'b0);
    IR = 32'h0000_0000;
    for (int t = 0; t < 6; t++) cyc(exp_step(5'd0, 1'b0, t), t == 5, 1'b0);
    cyc(34'd0, 1'b1, 1'b0);
    cyc(34'd0, 1'b1, 1'b0);
    cyc(34'd0, 1'b0, 1'b0);
    run(32'h0B00_0003, 1'b0, 1'b0);
    run(32'hA300_0000, 1'b0, 1'b0);
    run(32'hAB78_0000, 1'b0, 1'b0);
    run(32'h9880_0000, 1'b0, 1'b0);
    run(32'h9880_0000, 1'b1, 1'b0);
    run(32'h0000_0000, 1'b0, 1'b0);
    run(32'h1000_0000, 1'b0, 1'b0);
    run(32'h7800_0000, 1'b0, 1'b0);
    run(32'hF800_0000, 1'b0, 1'b0);
    run(32'h1800_0000, 1'b0, 1'b1);
    halted_restart(3);
    run(32'hD800_0000, 1'b0, 1'b0);
    halted_restart(3);
    for (int i = 0; i < 300; i++) begin
      op = 5'($urandom_range(0, 31));
      ir = {op, 27'($urandom)};
      stp = ($urandom_range(0, 7) == 0);
      run(ir, 1'($urandom_range(0, 1)), stp);
      if (stp || op == 5'd27) halted_restart(int'($urandom_range(1, 3)));
    end
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge Clock);
    #1;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, required completion before 500000");
    $fatal(1, "timeout");
  end
endmodule
